// File: rtl/i2c_pkg.sv
// Shared constants for the I2C register-access controller: byte-engine command
// bits, FSM state encoding and the default watchdog limit.
package i2c_pkg;

   localparam logic [4:0] CMD_START = 5'b0_0001;
   localparam logic [4:0] CMD_WRITE = 5'b0_0010;
   localparam logic [4:0] CMD_READ  = 5'b0_0100;
   localparam logic [4:0] CMD_STOP  = 5'b0_1000;
   localparam logic [4:0] CMD_ACK   = 5'b1_0000;

   localparam logic [15:0] TIMEOUT_CYC_DEF = 16'd20000;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_DEV_W  = 3'd1,
      ST_REG    = 3'd2,
      ST_WDATA  = 3'd3,
      ST_RSTART = 3'd4,
      ST_RDATA  = 3'd5,
      ST_RESP   = 3'd6
   } state_e;

   // Bytes the master transmits; only these carry a slave ACK bit worth sampling.
   function automatic logic is_wr_byte(input state_e s);
      return (s == ST_DEV_W) || (s == ST_REG) || (s == ST_WDATA) || (s == ST_RSTART);
   endfunction

endpackage

// File: rtl/i2c_reg_ctrl.sv
// I2C register read/write sequencer driving a byte engine that sits beside it.
// Optional engine-response watchdog enabled by defining I2C_TIMEOUT_EN.
//
// state   | meaning
// IDLE    | req_rdy high, waiting for a request
// DEV_W   | device address + write bit, with START
// REG     | register address byte
// WDATA   | write data byte, with STOP
// RSTART  | repeated START, device address + read bit
// RDATA   | read one byte, master NACK, STOP
// RESP    | one-cycle completion pulse
// Each byte state has an ISSUE cycle (wait_q=0) and a WAIT phase (wait_q=1).
module i2c_reg_ctrl
   import i2c_pkg::*;
#(
   parameter logic [15:0] TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
   input  logic       sys_clk,
   input  logic       sys_rst_n,
   input  logic       req_vld,
   output logic       req_rdy,
   input  logic       req_rw,
   input  logic [6:0] req_dev,
   input  logic [7:0] req_reg,
   input  logic [7:0] req_wdata,
   output logic       resp_vld,
   output logic [7:0] resp_rdata,
   output logic       resp_nack,
   output logic       resp_tmo,
   output logic [4:0] eng_cmd,
   output logic       eng_cmd_vld,
   output logic [7:0] eng_wr_data,
   input  logic [7:0] eng_rd_data,
   input  logic       eng_rd_data_vld,
   input  logic       eng_rev_ack,
   input  logic       eng_done
);

   state_e     state_q, state_d;
   logic       wait_q, wait_d;
   logic       rw_q;
   logic [6:0] dev_q;
   logic [7:0] reg_q, wdata_q;
   logic       nack_q;
   logic [7:0] rdata_q;
   logic       byte_st, issue, accept, tmo_hit;

   assign byte_st = (state_q != ST_IDLE) && (state_q != ST_RESP);
   assign issue   = byte_st && !wait_q;
   assign accept  = (state_q == ST_IDLE) && req_vld;

`ifdef I2C_TIMEOUT_EN
   logic [15:0] wd_q;
   logic        tmo_q;

   // Abort on the cycle the counter would reach TIMEOUT_CYC-1, so RESP lands
   // exactly TIMEOUT_CYC cycles after the ISSUE cycle.
   assign tmo_hit = byte_st && wait_q && !eng_done
                    && ((wd_q + 16'd1) == (TIMEOUT_CYC - 16'd1));

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         wd_q  <= '0;
         tmo_q <= 1'b0;
      end else begin
         wd_q <= (byte_st && wait_q) ? wd_q + 16'd1 : 16'd0;
         if (accept)
            tmo_q <= 1'b0;
         else if (tmo_hit)
            tmo_q <= 1'b1;
      end
   end

   assign resp_tmo = tmo_q;
`else
   logic unused_tmo;
   assign unused_tmo = ^TIMEOUT_CYC;
   assign tmo_hit    = 1'b0;
   assign resp_tmo   = 1'b0;
`endif

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state_q <= ST_IDLE;
         wait_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         wait_q  <= wait_d;
      end
   end

   always_comb begin
      state_d = state_q;
      wait_d  = wait_q;
      case (state_q)
         ST_IDLE: begin
            wait_d = 1'b0;
            if (req_vld)
               state_d = ST_DEV_W;
         end
         ST_RESP: begin
            state_d = ST_IDLE;
            wait_d  = 1'b0;
         end
         default: begin
            if (!wait_q) begin
               wait_d = 1'b1;
            end else if (eng_done) begin
               wait_d = 1'b0;
               case (state_q)
                  ST_DEV_W:  state_d = ST_REG;
                  ST_REG:    state_d = rw_q ? ST_RSTART : ST_WDATA;
                  ST_RSTART: state_d = ST_RDATA;
                  default:   state_d = ST_RESP;
               endcase
            end else if (tmo_hit) begin
               state_d = ST_RESP;
               wait_d  = 1'b0;
            end
         end
      endcase
   end

   always_comb begin
      req_rdy     = (state_q == ST_IDLE);
      resp_vld    = (state_q == ST_RESP);
      eng_cmd_vld = issue;
      eng_cmd     = '0;
      eng_wr_data = '0;
      if (issue) begin
         case (state_q)
            ST_DEV_W: begin
               eng_cmd     = CMD_START | CMD_WRITE;
               eng_wr_data = {dev_q, 1'b0};
            end
            ST_REG: begin
               eng_cmd     = CMD_WRITE;
               eng_wr_data = reg_q;
            end
            ST_WDATA: begin
               eng_cmd     = CMD_WRITE | CMD_STOP;
               eng_wr_data = wdata_q;
            end
            ST_RSTART: begin
               eng_cmd     = CMD_START | CMD_WRITE;
               eng_wr_data = {dev_q, 1'b1};
            end
            ST_RDATA: eng_cmd = CMD_READ | CMD_ACK | CMD_STOP;
            default: ;
         endcase
      end
   end

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         rw_q    <= 1'b0;
         dev_q   <= '0;
         reg_q   <= '0;
         wdata_q <= '0;
         nack_q  <= 1'b0;
         rdata_q <= '0;
      end else begin
         if (accept) begin
            rw_q    <= req_rw;
            dev_q   <= req_dev;
            reg_q   <= req_reg;
            wdata_q <= req_wdata;
            nack_q  <= 1'b0;
         end else if (byte_st && wait_q && eng_done && is_wr_byte(state_q)) begin
            nack_q <= nack_q | eng_rev_ack;
         end
         if ((state_q == ST_RDATA) && eng_rd_data_vld)
            rdata_q <= eng_rd_data;
      end
   end

   assign resp_rdata = rdata_q;
   assign resp_nack  = nack_q;

endmodule

// File: tb/tb_i2c_reg_ctrl.sv
// Self-checking bench for i2c_reg_ctrl with a behavioural byte-engine model.
// Timeout scenario is exercised when I2C_TIMEOUT_EN is defined.
module tb_i2c_reg_ctrl;

   logic       sys_clk = 1'b0;
   logic       sys_rst_n = 1'b0;
   logic       req_vld = 1'b0, req_rdy, req_rw = 1'b0;
   logic [6:0] req_dev = '0;
   logic [7:0] req_reg = '0, req_wdata = '0;
   logic       resp_vld, resp_nack, resp_tmo;
   logic [7:0] resp_rdata;
   logic [4:0] eng_cmd;
   logic       eng_cmd_vld;
   logic [7:0] eng_wr_data;
   logic [7:0] eng_rd_data = '0;
   logic       eng_rd_data_vld = 1'b0, eng_rev_ack = 1'b0, eng_done = 1'b0;

   int vectors = 0, errors = 0, cyc = 0;
   logic [12:0] seen_q[$];
   int          issue_cyc_q[$];
   logic [12:0] exp_q[$];
   int   eng_bytes = 0, plan_base = 0, fixed_lat = 0;
   int   wait_viol = 0, viol_seen = 0, kick_cnt = 0, kick_done = 0;
   bit   hang = 1'b0;
   bit   ack_plan [16];
   logic [7:0] rd_plan = '0, model_rdata = '0;

   i2c_reg_ctrl #(.TIMEOUT_CYC(16'd100)) dut (
      .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
      .req_vld(req_vld), .req_rdy(req_rdy), .req_rw(req_rw),
      .req_dev(req_dev), .req_reg(req_reg), .req_wdata(req_wdata),
      .resp_vld(resp_vld), .resp_rdata(resp_rdata), .resp_nack(resp_nack),
      .resp_tmo(resp_tmo), .eng_cmd(eng_cmd), .eng_cmd_vld(eng_cmd_vld),
      .eng_wr_data(eng_wr_data), .eng_rd_data(eng_rd_data),
      .eng_rd_data_vld(eng_rd_data_vld), .eng_rev_ack(eng_rev_ack),
      .eng_done(eng_done)
   );

   always #5 sys_clk = ~sys_clk;
   always @(posedge sys_clk) cyc <= cyc + 1;

   // Engine model: one command at a time, answers after a latency.
   task automatic serve();
      int lat, idx;
      logic [4:0] c;
      c = eng_cmd;
      seen_q.push_back({eng_cmd, eng_wr_data});
      issue_cyc_q.push_back(cyc);
      idx = (eng_bytes - plan_base) & 15;
      eng_bytes++;
      lat = (fixed_lat != 0) ? fixed_lat : int'($urandom_range(1, 5));
      for (int k = 0; k < lat; k++) begin
         @(negedge sys_clk);
         if (sys_rst_n !== 1'b1) return;
         if (eng_cmd_vld !== 1'b0) wait_viol++;
      end
      if (hang) return;
      eng_done = 1'b1;
      eng_rev_ack = ack_plan[idx];
      if (c[2]) begin
         eng_rd_data = rd_plan;
         eng_rd_data_vld = 1'b1;
      end
      @(negedge sys_clk);
      eng_done = 1'b0;
      eng_rd_data_vld = 1'b0;
      eng_rd_data = 8'($urandom);
   endtask

   initial begin : engine
      forever begin
         @(negedge sys_clk);
         if (kick_cnt != kick_done) begin
            kick_done = kick_cnt;
            eng_done = 1'b1;
            eng_rev_ack = 1'b0;
            @(negedge sys_clk);
            eng_done = 1'b0;
         end
         while (eng_cmd_vld === 1'b1 && sys_rst_n === 1'b1) serve();
      end
   end

   // Reference: the byte sequence an I2C register access must produce.
   function automatic void add_exp(bit rw, logic [6:0] dev, logic [7:0] rg, logic [7:0] wd);
      exp_q.push_back({5'h03, dev, 1'b0});
      exp_q.push_back({5'h02, rg});
      if (!rw) begin
         exp_q.push_back({5'h0A, wd});
      end else begin
         exp_q.push_back({5'h03, dev, 1'b1});
         exp_q.push_back({5'h1C, 8'h00});
      end
   endfunction

   task automatic check_cmds(string tag, int base);
      logic [12:0] m;
      vectors++;
      if (seen_q.size() - base != exp_q.size()) begin
         errors++;
         $display("FAIL %s cmd_count: got %0d expected %0d", tag, seen_q.size() - base, exp_q.size());
      end else begin
         foreach (exp_q[i]) begin
            m = exp_q[i][10] ? 13'h1F00 : 13'h1FFF;
            vectors++;
            if ((seen_q[base+i] & m) !== (exp_q[i] & m)) begin
               errors++;
               $display("FAIL %s cmd[%0d]: got %h/%h expected %h/%h", tag, i,
                        seen_q[base+i][12:8], seen_q[base+i][7:0], exp_q[i][12:8], exp_q[i][7:0]);
            end
         end
      end
      vectors++;
      if (wait_viol != viol_seen) begin
         errors++;
         $display("FAIL %s cmd_vld_in_wait: got %0d strobes expected 0", tag, wait_viol - viol_seen);
         viol_seen = wait_viol;
      end
   endtask

   task automatic wait_resp(input int budget, output int rc, output bit ok);
      ok = 1'b0;
      rc = 0;
      for (int n = 0; n < budget; n++) begin
         @(negedge sys_clk);
         if (resp_vld === 1'b1) begin
            ok = 1'b1;
            rc = cyc;
            break;
         end
      end
   endtask

   task automatic accept_req(bit rw, logic [6:0] dev, logic [7:0] rg, logic [7:0] wd);
      bit ok;
      @(negedge sys_clk);
      req_rw = rw; req_dev = dev; req_reg = rg; req_wdata = wd; req_vld = 1'b1;
      ok = 1'b0;
      for (int n = 0; n < 50; n++) begin
         if (req_rdy === 1'b1) begin ok = 1'b1; break; end
         @(negedge sys_clk);
      end
      vectors++;
      if (!ok) begin errors++; $display("FAIL accept: req_rdy got %b expected 1", req_rdy); end
      @(negedge sys_clk);
      req_vld = 1'b0;
      req_rw = 1'($urandom); req_dev = 7'($urandom); req_reg = 8'($urandom); req_wdata = 8'($urandom);
   endtask

   task automatic do_txn(bit rw, logic [6:0] dev, logic [7:0] rg, logic [7:0] wd,
                         logic [7:0] rdv, string tag);
      bit ok; int rc, base; logic exp_nack; logic [7:0] exp_rd;
      exp_q.delete();
      base = seen_q.size();
      plan_base = eng_bytes;
      rd_plan = rdv;
      add_exp(rw, dev, rg, wd);
      exp_nack = ack_plan[0] | ack_plan[1] | ack_plan[2];
      exp_rd = rw ? rdv : model_rdata;
      accept_req(rw, dev, rg, wd);
      wait_resp(500, rc, ok);
      vectors++;
      if (!ok) begin
         errors++;
         $display("FAIL %s resp_wait: resp_vld got 0 expected 1 within 500 cycles", tag);
      end else begin
         vectors += 3;
         if (resp_nack !== exp_nack) begin errors++; $display("FAIL %s nack: got %b expected %b", tag, resp_nack, exp_nack); end
         if (resp_tmo !== 1'b0) begin errors++; $display("FAIL %s tmo: got %b expected 0", tag, resp_tmo); end
         if (resp_rdata !== exp_rd) begin errors++; $display("FAIL %s rdata: got %h expected %h", tag, resp_rdata, exp_rd); end
         model_rdata = exp_rd;
         @(negedge sys_clk);
         vectors += 2;
         if (resp_vld !== 1'b0) begin errors++; $display("FAIL %s resp_pulse: got %b expected 0", tag, resp_vld); end
         if (req_rdy !== 1'b1) begin errors++; $display("FAIL %s rdy_after_resp: got %b expected 1", tag, req_rdy); end
      end
      check_cmds(tag, base);
   endtask

   task automatic clear_plan();
      foreach (ack_plan[i]) ack_plan[i] = 1'b0;
   endtask

   task automatic check_reset_outputs(string tag);
      vectors += 8;
      if (req_rdy !== 1'b1) begin errors++; $display("FAIL %s req_rdy: got %b expected 1", tag, req_rdy); end
      if (resp_vld !== 1'b0) begin errors++; $display("FAIL %s resp_vld: got %b expected 0", tag, resp_vld); end
      if (resp_rdata !== 8'h00) begin errors++; $display("FAIL %s resp_rdata: got %h expected 00", tag, resp_rdata); end
      if (resp_nack !== 1'b0) begin errors++; $display("FAIL %s resp_nack: got %b expected 0", tag, resp_nack); end
      if (resp_tmo !== 1'b0) begin errors++; $display("FAIL %s resp_tmo: got %b expected 0", tag, resp_tmo); end
      if (eng_cmd !== 5'h00) begin errors++; $display("FAIL %s eng_cmd: got %h expected 00", tag, eng_cmd); end
      if (eng_cmd_vld !== 1'b0) begin errors++; $display("FAIL %s eng_cmd_vld: got %b expected 0", tag, eng_cmd_vld); end
      if (eng_wr_data !== 8'h00) begin errors++; $display("FAIL %s eng_wr_data: got %h expected 00", tag, eng_wr_data); end
   endtask

   task automatic test_reset();
      repeat (2) @(negedge sys_clk);
      check_reset_outputs("reset");
      sys_rst_n = 1'b1;
   endtask

   task automatic test_spurious_done();
      int bad = 0;
      kick_cnt++;
      repeat (5) begin
         @(negedge sys_clk);
         if (resp_vld !== 1'b0 || req_rdy !== 1'b1 || eng_cmd_vld !== 1'b0) bad++;
      end
      vectors++;
      if (bad != 0) begin errors++; $display("FAIL spurious_done: got %0d disturbed cycles expected 0", bad); end
   endtask

   task automatic test_directed();
      clear_plan();
      do_txn(1'b0, 7'h54, 8'h00, 8'hA5, 8'h00, "write_dir");
      do_txn(1'b1, 7'h54, 8'h10, 8'h00, 8'h3C, "read_dir");
      clear_plan();
      ack_plan[1] = 1'b1;
      do_txn(1'b0, 7'h54, 8'h22, 8'h5A, 8'h00, "nack_reg");
   endtask

   task automatic test_random();
      for (int t = 0; t < 24; t++) begin
         foreach (ack_plan[i]) ack_plan[i] = ($urandom_range(0, 3) == 0);
         do_txn(1'($urandom), 7'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), "random");
      end
   endtask

   task automatic test_back_to_back();
      int base, r1, r2, a2; bit ok;
      logic [6:0] dva, dvb; logic [7:0] ra, rb, wa, rdv; logic na, nb;
      dva = 7'($urandom); dvb = 7'($urandom); ra = 8'($urandom); rb = 8'($urandom);
      wa = 8'($urandom); rdv = 8'($urandom); a2 = 0;
      foreach (ack_plan[i]) ack_plan[i] = ($urandom_range(0, 2) == 0);
      na = ack_plan[0] | ack_plan[1] | ack_plan[2];
      nb = ack_plan[3] | ack_plan[4] | ack_plan[5];
      exp_q.delete();
      base = seen_q.size();
      plan_base = eng_bytes;
      rd_plan = rdv;
      add_exp(1'b0, dva, ra, wa);
      add_exp(1'b1, dvb, rb, 8'h00);
      @(negedge sys_clk);
      req_rw = 1'b0; req_dev = dva; req_reg = ra; req_wdata = wa; req_vld = 1'b1;
      ok = 1'b0;
      for (int n = 0; n < 50; n++) begin
         if (req_rdy === 1'b1) begin ok = 1'b1; break; end
         @(negedge sys_clk);
      end
      vectors++;
      if (!ok) begin errors++; $display("FAIL b2b accept1: req_rdy got 0 expected 1"); end
      @(negedge sys_clk);
      req_rw = 1'b1; req_dev = dvb; req_reg = rb; req_wdata = 8'($urandom);
      wait_resp(500, r1, ok);
      vectors++;
      if (!ok) begin
         errors++; $display("FAIL b2b resp1_wait: resp_vld got 0 expected 1");
      end else begin
         vectors += 3;
         if (resp_nack !== na) begin errors++; $display("FAIL b2b nack1: got %b expected %b", resp_nack, na); end
         if (req_rdy !== 1'b0) begin errors++; $display("FAIL b2b rdy_in_resp: got %b expected 0", req_rdy); end
         if (resp_rdata !== model_rdata) begin errors++; $display("FAIL b2b rdata_hold: got %h expected %h", resp_rdata, model_rdata); end
      end
      ok = 1'b0;
      for (int n = 0; n < 10; n++) begin
         @(negedge sys_clk);
         if (req_rdy === 1'b1) begin ok = 1'b1; a2 = cyc; break; end
      end
      vectors++;
      if (!ok || a2 != r1 + 1) begin errors++; $display("FAIL b2b accept2_cycle: got %0d expected %0d", a2, r1 + 1); end
      @(negedge sys_clk);
      req_vld = 1'b0;
      wait_resp(500, r2, ok);
      vectors++;
      if (!ok) begin
         errors++; $display("FAIL b2b resp2_wait: resp_vld got 0 expected 1");
      end else begin
         vectors += 2;
         if (resp_nack !== nb) begin errors++; $display("FAIL b2b nack2: got %b expected %b", resp_nack, nb); end
         if (resp_rdata !== rdv) begin errors++; $display("FAIL b2b rdata2: got %h expected %h", resp_rdata, rdv); end
         model_rdata = rdv;
      end
      @(negedge sys_clk);
      check_cmds("b2b", base);
   endtask

   task automatic test_reset_mid();
      int base, nresp; bit ok;
      clear_plan();
      fixed_lat = 20;
      base = seen_q.size();
      plan_base = eng_bytes;
      accept_req(1'b0, 7'($urandom), 8'($urandom), 8'($urandom));
      ok = 1'b0;
      for (int n = 0; n < 200; n++) begin
         if (seen_q.size() >= base + 2) begin ok = 1'b1; break; end
         @(negedge sys_clk);
      end
      vectors++;
      if (!ok) begin errors++; $display("FAIL rst_mid reach_reg: got %0d bytes expected 2", seen_q.size() - base); end
      repeat (3) @(negedge sys_clk);
      sys_rst_n = 1'b0;
      @(negedge sys_clk);
      check_reset_outputs("rst_mid");
      repeat (2) @(negedge sys_clk);
      sys_rst_n = 1'b1;
      fixed_lat = 0;
      model_rdata = 8'h00;
      nresp = 0;
      repeat (10) begin
         @(negedge sys_clk);
         if (resp_vld === 1'b1) nresp++;
      end
      vectors += 2;
      if (nresp != 0) begin errors++; $display("FAIL rst_mid no_resp: got %0d pulses expected 0", nresp); end
      if (req_rdy !== 1'b1) begin errors++; $display("FAIL rst_mid rdy: got %b expected 1", req_rdy); end
      do_txn(1'b1, 7'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), "after_rst");
   endtask

`ifdef I2C_TIMEOUT_EN
   task automatic test_timeout();
      int base, rc; bit ok;
      clear_plan();
      hang = 1'b1;
      base = seen_q.size();
      plan_base = eng_bytes;
      accept_req(1'b0, 7'($urandom), 8'($urandom), 8'($urandom));
      wait_resp(400, rc, ok);
      vectors++;
      if (!ok || issue_cyc_q.size() <= base) begin
         errors++; $display("FAIL timeout resp_wait: resp_vld got 0 expected 1");
      end else begin
         vectors += 2;
         if (rc - issue_cyc_q[base] != 100) begin
            errors++; $display("FAIL timeout latency: got %0d expected 100", rc - issue_cyc_q[base]);
         end
         if (resp_tmo !== 1'b1) begin errors++; $display("FAIL timeout tmo: got %b expected 1", resp_tmo); end
      end
      hang = 1'b0;
      @(negedge sys_clk);
      do_txn(1'b0, 7'($urandom), 8'($urandom), 8'($urandom), 8'h00, "after_tmo");
   endtask
`else
   task automatic test_no_timeout();
      int base, rc, nresp; bit ok; logic [6:0] dv; logic [7:0] rg, wd;
      clear_plan();
      dv = 7'($urandom); rg = 8'($urandom); wd = 8'($urandom);
      exp_q.delete();
      add_exp(1'b0, dv, rg, wd);
      hang = 1'b1;
      base = seen_q.size();
      plan_base = eng_bytes;
      accept_req(1'b0, dv, rg, wd);
      nresp = 0;
      repeat (300) begin
         @(negedge sys_clk);
         if (resp_vld === 1'b1) nresp++;
      end
      vectors += 3;
      if (nresp != 0) begin errors++; $display("FAIL no_tmo wait_unbounded: got %0d pulses expected 0", nresp); end
      if (resp_tmo !== 1'b0) begin errors++; $display("FAIL no_tmo tmo: got %b expected 0", resp_tmo); end
      if (req_rdy !== 1'b0) begin errors++; $display("FAIL no_tmo busy: req_rdy got %b expected 0", req_rdy); end
      hang = 1'b0;
      kick_cnt++;
      wait_resp(500, rc, ok);
      vectors++;
      if (!ok) begin
         errors++; $display("FAIL no_tmo resume: resp_vld got 0 expected 1");
      end else begin
         vectors += 2;
         if (resp_tmo !== 1'b0) begin errors++; $display("FAIL no_tmo tmo_end: got %b expected 0", resp_tmo); end
         if (resp_nack !== 1'b0) begin errors++; $display("FAIL no_tmo nack: got %b expected 0", resp_nack); end
      end
      @(negedge sys_clk);
      check_cmds("no_tmo", base);
   endtask
`endif

   initial begin : guard
      #500000;
      $display("FAIL global_timeout: simulation got stuck expected completion");
      $fatal(1, "bench stopped");
   end

   initial begin : main
      test_reset();
      test_spurious_done();
      test_directed();
      test_random();
      test_back_to_back();
      test_reset_mid();
`ifdef I2C_TIMEOUT_EN
      test_timeout();
`else
      test_no_timeout();
`endif
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule

// File: doc/i2c_reg_ctrl.md
I2C_REG_CTRL -- requirements
Module: i2c_reg_ctrl

Interface
REQ-001 Parameter TIMEOUT_CYC, default 20000, SHALL set the engine-response watchdog limit in sys_clk cycles (16-bit).
REQ-002 sys_clk  in  1  system clock; all logic SHALL be on its rising edge.
REQ-003 sys_rst_n  in  1  SHALL be an asynchronous, active-low reset.
REQ-004 req_vld  in  1  transaction request.
REQ-005 req_rdy  out  1  high only in IDLE; a request SHALL be accepted when req_vld and req_rdy are both high.
REQ-006 req_rw  in  1  0 = register write, 1 = register read.
REQ-007 req_dev  in  7  slave device address.
REQ-008 req_reg  in  8  register address.
REQ-009 req_wdata  in  8  write data.
REQ-010 resp_vld  out  1  one-cycle completion pulse.
REQ-011 resp_rdata  out  8  read data, valid with resp_vld on reads.
REQ-012 resp_nack  out  1  at least one NACK seen, valid with resp_vld.
REQ-013 resp_tmo  out  1  watchdog abort, valid with resp_vld.
REQ-014 eng_cmd  out  5  byte-engine command: bit0 START, bit1 WRITE, bit2 READ, bit3 STOP, bit4 ACK (master NACK on read).
REQ-015 eng_cmd_vld  out  1  one-cycle command strobe.
REQ-016 eng_wr_data  out  8  byte to transmit.
REQ-017 eng_rd_data / eng_rd_data_vld  in  8/1  received byte and its strobe.
REQ-018 eng_rev_ack  in  1  slave ACK bit, 0 = ACK, held until the next ACK phase.
REQ-019 eng_done  in  1  engine byte-complete pulse.

Function
REQ-020 FSM states SHALL be IDLE, DEV_W, REG, WDATA, RSTART, RDATA and RESP; every byte state SHALL have an ISSUE cycle and a WAIT phase.
REQ-021 ISSUE SHALL drive eng_cmd_vld high for exactly one cycle with eng_cmd/eng_wr_data stable, then enter WAIT until eng_done.
REQ-022 Write sequence SHALL be: DEV_W {START|WRITE, dev<<1|0}, REG {WRITE, reg}, WDATA {WRITE|STOP, wdata}, then RESP.
REQ-023 Read sequence SHALL be: DEV_W {START|WRITE, dev<<1|0}, REG {WRITE, reg}, RSTART {START|WRITE, dev<<1|1}, RDATA {READ|ACK|STOP}, then RESP.
REQ-024 Request fields SHALL be latched on acceptance; input changes during a transaction SHALL be ignored.
REQ-025 In each write-byte WAIT, eng_rev_ack SHALL be sampled in the eng_done cycle and OR-ed into a sticky NACK flag cleared on acceptance.
REQ-026 A NACK SHALL NOT abort the sequence, so STOP is always issued.
REQ-027 resp_rdata SHALL capture eng_rd_data on eng_rd_data_vld in RDATA, and SHALL hold its value until the next read capture.
REQ-028 RESP SHALL last one cycle with resp_vld=1, then return to IDLE; req_rdy SHALL rise the following cycle.
REQ-029 An eng_done outside WAIT SHALL be ignored.
REQ-030 eng_cmd_vld SHALL never be asserted while in WAIT.

Reset
REQ-031 While reset is asserted, the block SHALL be in IDLE with req_rdy=1, resp_vld=0, resp_rdata=0, resp_nack=0, resp_tmo=0, eng_cmd=0, eng_cmd_vld=0, eng_wr_data=0 and the watchdog counter=0.
REQ-032 Reset asserted mid-transaction SHALL abandon the transaction with no resp_vld.

Configuration
REQ-033 With I2C_TIMEOUT_EN defined, a 16-bit counter SHALL count every WAIT cycle and clear on each ISSUE.
REQ-034 With I2C_TIMEOUT_EN defined, reaching TIMEOUT_CYC-1 without eng_done SHALL go to RESP with resp_tmo=1.
REQ-035 With I2C_TIMEOUT_EN undefined, the counter SHALL be absent, WAIT SHALL be unbounded, and resp_tmo SHALL be tied 0.

Structure
REQ-036 Shared package i2c_pkg SHALL hold the command bit constants (START/WRITE/READ/STOP/ACK), the FSM state encoding and the TIMEOUT_CYC default.
REQ-037 The block SHALL have no sub-modules; the byte engine SHALL be instantiated beside it at the next level up.

Verification
REQ-038 Write dev=0x54 reg=0x00 wdata=0xA5 with the engine model ACKing -> commands 0x03/0xA8, 0x02/0x00, 0x0A/0xA5, then resp_vld with resp_nack=0.
REQ-039 Read dev=0x54 reg=0x10 with the model returning 0x3C -> commands 0x03/0xA8, 0x02/0x10, 0x03/0xA9, 0x1C, then resp_rdata=0x3C and resp_nack=0.
REQ-040 Write with eng_rev_ack=1 on the REG byte -> all three commands still issued, then resp_nack=1.
REQ-041 req_vld held high across two back-to-back requests -> the second is accepted only one cycle after the first resp_vld, with no overlapping eng_cmd_vld.
REQ-042 Reset pulsed during REG WAIT -> IDLE, req_rdy=1, no resp_vld; the next request completes normally.
REQ-043 With I2C_TIMEOUT_EN and TIMEOUT_CYC=100, engine model never asserts eng_done -> resp_vld with resp_tmo=1 exactly 100 cycles after the ISSUE cycle.
